// File: rtl/count_game_ctrl.sv
// Round sequencer for the dot-matrix counting game: shows a pseudo-random target,
// runs the counter, judges the stop against the live count and keeps the score.
module count_game_ctrl #(
    parameter int unsigned ROUNDS    = 4,
    parameter int unsigned SHOW_CYC  = 16,
    parameter int unsigned RES_CYC   = 16,
    parameter logic [2:0]  LFSR_SEED = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic       stop_key,
    input  logic [2:0] cur_val,
    input  logic       cnt_done,
    output logic       cst,
    output logic [2:0] num,
    output logic       dzst,
    output logic [2:0] round,
    output logic [2:0] score,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    localparam int unsigned MaxCyc = (SHOW_CYC > RES_CYC) ? SHOW_CYC : RES_CYC;
    localparam int unsigned TimerW = $clog2(MaxCyc) + 1;
    localparam logic [TimerW-1:0] ShowLast  = TimerW'(SHOW_CYC - 1);
    localparam logic [TimerW-1:0] ResLast   = TimerW'(RES_CYC - 1);
    localparam logic [2:0]        LastRound = 3'(ROUNDS);

    typedef enum logic [2:0] {StIdle, StShow, StRun, StResult, StOver} state_e;

    state_e            state_q;
    logic [TimerW-1:0] timer_q;
    logic [2:0]        lfsr_q;
    logic [2:0]        lfsr_next;

    // Taps chosen for a maximal period of 7; the all-zero state is unreachable.
    assign lfsr_next = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            cst       <= 1'b0;
            num       <= 3'd0;
            dzst      <= 1'b0;
            round     <= 3'd0;
            score     <= 3'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_key) begin
                        state_q <= StShow;
                        round   <= 3'd1;
                        score   <= 3'd0;
                        num     <= lfsr_q;
                        lfsr_q  <= lfsr_next;
                        timer_q <= '0;
                        dzst    <= 1'b1;
                    end
                end
                StShow: begin
                    if (timer_q == ShowLast) begin
                        state_q <= StRun;
                        timer_q <= '0;
                        cst     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StRun: begin
                    // stop_key takes priority over a coincident cnt_done
                    if (stop_key) begin
                        state_q <= StResult;
                        timer_q <= '0;
                        cst     <= 1'b0;
                        if (cur_val == num) begin
                            hit   <= 1'b1;
                            score <= score + 3'd1;
                        end else begin
                            miss  <= 1'b1;
                        end
                    end else if (cnt_done) begin
                        state_q <= StResult;
                        timer_q <= '0;
                        cst     <= 1'b0;
                        miss    <= 1'b1;
                    end
                end
                StResult: begin
                    if (timer_q == ResLast) begin
                        timer_q <= '0;
                        hit     <= 1'b0;
                        miss    <= 1'b0;
                        if (round == LastRound) begin
                            state_q   <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            state_q <= StShow;
                            round   <= round + 3'd1;
                            num     <= lfsr_q;
                            lfsr_q  <= lfsr_next;
                        end
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StOver: begin
                    // LFSR is left running so the next game continues the sequence
                    if (start_key) begin
                        state_q   <= StIdle;
                        game_over <= 1'b0;
                        round     <= 3'd0;
                        score     <= 3'd0;
                        dzst      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench for count_game_ctrl: one full game, a second partial game and a
// mid-RUN reset, with expected values worked out by hand.
module tb_count_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_key, stop_key, cnt_done;
    logic [2:0] cur_val;
    logic       cst, dzst, hit, miss, game_over;
    logic [2:0] num, round, score;

    int total = 0;
    int bad   = 0;

    count_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_key (start_key),
        .stop_key  (stop_key),
        .cur_val   (cur_val),
        .cnt_done  (cnt_done),
        .cst       (cst),
        .num       (num),
        .dzst      (dzst),
        .round     (round),
        .score     (score),
        .hit       (hit),
        .miss      (miss),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_key = 1'b1; step(); start_key = 1'b0;
    endtask

    task automatic pulse_stop(input logic [2:0] v, input logic done);
        cur_val = v; stop_key = 1'b1; cnt_done = done; step();
        stop_key = 1'b0; cnt_done = 1'b0;
    endtask

    // From SHOW entry: cst must stay low 15 more cycles, then rise on the 16th.
    task automatic to_run(input string tag);
        repeat (15) step();
        chk({tag, "_pre_cst"}, {7'd0, cst}, 8'd0);
        step();
        chk({tag, "_cst"}, {7'd0, cst}, 8'd1);
    endtask

    // From RESULT entry: flag held 15 more cycles, then cleared.
    task automatic finish_result(input string tag, input logic exp_hit);
        repeat (15) step();
        chk({tag, "_held"}, {6'd0, hit, miss}, exp_hit ? 8'd2 : 8'd1);
        step();
        chk({tag, "_clear"}, {6'd0, hit, miss}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; start_key = 1'b0; stop_key = 1'b0; cnt_done = 1'b0; cur_val = 3'd0;
        #100;
        chk("rst_outs", {cst, dzst, hit, miss, game_over, 3'd0}, 8'd0);
        chk("rst_num_round", {2'd0, num, round}, 8'd0);
        chk("rst_score", {5'd0, score}, 8'd0);
        #100;
        step(); rst = 1'b0;
        step();

        // start ignored? no: IDLE accepts it
        pulse_start();
        chk("g1r1_round", {5'd0, round}, 8'd1);
        chk("g1r1_num", {5'd0, num}, 8'd5);
        chk("g1r1_dzst", {7'd0, dzst}, 8'd1);
        // stop_key during SHOW must be ignored
        stop_key = 1'b1; step(); stop_key = 1'b0;
        chk("show_stop_ign", {6'd0, hit, miss}, 8'd0);
        repeat (14) step();
        chk("g1r1_pre_cst", {7'd0, cst}, 8'd0);
        step();
        chk("g1r1_cst", {7'd0, cst}, 8'd1);

        // start_key ignored in RUN
        pulse_start();
        chk("run_start_ign", {round, 4'd0, cst}, {3'd1, 4'd0, 1'b1});

        // round 1: hit
        pulse_stop(3'd5, 1'b0);
        chk("hit_cst", {7'd0, cst}, 8'd0);
        chk("hit_flags", {6'd0, hit, miss}, 8'd2);
        chk("hit_score", {5'd0, score}, 8'd1);
        finish_result("g1r1", 1'b1);
        chk("g1r2_num", {5'd0, num}, 8'd3);
        chk("g1r2_round", {5'd0, round}, 8'd2);

        // round 2: wrong value stop
        to_run("g1r2");
        pulse_stop(3'd2, 1'b0);
        chk("miss_flags", {6'd0, hit, miss}, 8'd1);
        chk("miss_score", {5'd0, score}, 8'd1);
        finish_result("g1r2", 1'b0);
        chk("g1r3_num", {5'd0, num}, 8'd7);

        // round 3: stop and cnt_done together on the target
        to_run("g1r3");
        pulse_stop(3'd7, 1'b1);
        chk("simul_flags", {6'd0, hit, miss}, 8'd2);
        chk("simul_score", {5'd0, score}, 8'd2);
        finish_result("g1r3", 1'b1);
        chk("g1r4_num", {5'd0, num}, 8'd6);

        // round 4: hit, then game over
        to_run("g1r4");
        repeat (3) step();
        pulse_stop(3'd6, 1'b0);
        chk("g1r4_score", {5'd0, score}, 8'd3);
        repeat (15) step();
        chk("pre_over", {7'd0, game_over}, 8'd0);
        step();
        chk("over", {7'd0, game_over}, 8'd1);
        chk("over_score", {5'd0, score}, 8'd3);
        chk("over_round", {5'd0, round}, 8'd4);
        chk("over_ctl", {6'd0, dzst, cst}, 8'd2);
        pulse_stop(3'd6, 1'b1);
        step();
        chk("over_ign", {score, hit, miss, game_over, 2'd0}, {3'd3, 1'b0, 1'b0, 1'b1, 2'd0});

        pulse_start();
        chk("idle_clear", {game_over, dzst, round, score[1:0]}, 8'd0);
        chk("idle_score", {5'd0, score}, 8'd0);

        // game 2: LFSR continues
        pulse_start();
        chk("g2r1_num", {5'd0, num}, 8'd4);
        chk("g2r1_round", {5'd0, round}, 8'd1);
        to_run("g2r1");
        cnt_done = 1'b1; step(); cnt_done = 1'b0;
        chk("done_flags", {6'd0, hit, miss}, 8'd1);
        chk("done_cst", {7'd0, cst}, 8'd0);
        chk("done_score", {5'd0, score}, 8'd0);
        finish_result("g2r1", 1'b0);
        chk("g2r2_num", {5'd0, num}, 8'd1);
        to_run("g2r2");

        // asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1;
        chk("arst_cst", {7'd0, cst}, 8'd0);
        chk("arst_outs", {dzst, hit, miss, game_over, 4'd0}, 8'd0);
        chk("arst_num_round", {2'd0, num, round}, 8'd0);
        step(); rst = 1'b0;
        step();
        pulse_start();
        chk("arst_lfsr_num", {5'd0, num}, 8'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_game_ctrl.md
# count_game_ctrl

Game sequencer for the dot-matrix counting game: drives the counter's `cst`/`num`/`dzst` controls through a fixed number of rounds. Each round picks a pseudo-random target, shows it, then runs the counter until the player presses stop or the counter expires. It judges hit/miss against the counter's live value and keeps the score. It sits between the debounced key inputs and the counter/dot-matrix block.

## Interface
Parameters:
- `ROUNDS`, 4: rounds per game, range 1..7.
- `SHOW_CYC`, 16: cycles the target is shown before counting starts, ≥1.
- `RES_CYC`, 16: cycles a round result is held, ≥1.
- `LFSR_SEED`, 3'b101: reset value of the target LFSR; must be non-zero.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_key`  in  1  one-cycle pulse, already debounced and synchronized upstream.
- `stop_key`  in  1  one-cycle pulse, already debounced and synchronized upstream.
- `cur_val`  in  3  value the counter is currently displaying.
- `cnt_done`  in  1  one-cycle pulse when the counter finishes its sequence.
- `cst`  out  1  counter start/run enable.
- `num`  out  3  target number passed to the counter.
- `dzst`  out  1  dot-matrix display enable.
- `round`  out  3  current round number, 1-based; 0 in IDLE.
- `score`  out  3  hits so far.
- `hit`  out  1  result flag, held through RESULT.
- `miss`  out  1  result flag, held through RESULT.
- `game_over`  out  1  high in OVER.

## Operation
- All outputs are registered. On reset:
  - state = IDLE.
  - `cst`, `dzst`, `hit`, `miss`, `game_over` = 0.
  - `num`, `round`, `score` = 0.
  - LFSR = `LFSR_SEED`.
  - Timer = 0.
- Target LFSR: 3-bit Fibonacci, next = {l[1:0], l[2]^l[1]}, period 7, never 0.
  - Advances only when SHOW is entered.
  - `num` loads the pre-advance LFSR value.
  - Seed 101 yields targets 5, 3, 7, 6, 4, 1, 2, then repeats.
- IDLE:
  - `dzst` = 0 and `cst` = 0.
  - `start_key` → SHOW. In the same transition: `round` = 1, `score` = 0, load `num`, timer = 0.
- SHOW:
  - `dzst` = 1 and `cst` = 0.
  - Timer counts to `SHOW_CYC`-1, then → RUN.
- RUN:
  - `dzst` = 1 and `cst` = 1.
  - `stop_key` → RESULT. If `cur_val` == `num`, set `hit` = 1 and `score` += 1; otherwise set `miss` = 1.
  - `cnt_done` without `stop_key` → RESULT with `miss` = 1.
  - `stop_key` and `cnt_done` in the same cycle: `stop_key` wins and is judged on that cycle's `cur_val`.
- RESULT:
  - `cst` = 0 and `dzst` = 1.
  - `hit`/`miss` are held for `RES_CYC` cycles, then cleared.
  - If `round` == `ROUNDS` → OVER. Otherwise → SHOW with `round` += 1 and a new `num`.
- OVER:
  - `game_over` = 1, `dzst` = 1, `cst` = 0.
  - `score` and `round` are frozen.
  - `start_key` → IDLE, clearing `game_over`, `round` and `score`. The LFSR is not reset, so the next game continues the sequence.
- `start_key` is ignored in SHOW, RUN and RESULT. `stop_key` is ignored outside RUN. `cnt_done` is ignored outside RUN.
- `hit` and `miss` are never high together. `score` ≤ `ROUNDS`, so it cannot wrap.
- An asynchronous `rst` at any point, including mid-RUN, returns everything to reset values immediately. `cst` drops with no delay.

## Timing
- `start_key` at cycle t in IDLE → SHOW, `dzst` = 1 and `num` valid at t+1.
- `cst` rises exactly `SHOW_CYC` cycles after SHOW entry.
- `stop_key` or `cnt_done` at cycle t in RUN:
  - `cst` = 0 and `hit`/`miss` valid at t+1; `score` updated at t+1.
  - `cur_val` is sampled at t.
- RESULT lasts exactly `RES_CYC` cycles.
  - Next round: `num` changes at the cycle SHOW is re-entered.
  - Last round: `game_over` = 1 on the cycle after RESULT ends.
- Minimum round length: `SHOW_CYC` + 1 + `RES_CYC` cycles (stop pressed in the first RUN cycle).

## Test plan
- Reset check: assert `rst` for 200 ns → all outputs 0. Release, pulse `start_key` → `round` = 1, `num` = 5, `dzst` = 1; `cst` rises 16 cycles later.
- Hit path: in RUN, drive `cur_val` = 5 and pulse `stop_key` → next cycle `cst` = 0, `hit` = 1, `score` = 1. `hit` clears after 16 cycles; round 2 begins with `num` = 3.
- Miss paths, run as separate rounds:
  - `stop_key` with `cur_val` = 2 against target 3 → `miss` = 1, `score` unchanged.
  - `cnt_done` alone → `miss` = 1.
- Simultaneous `stop_key` and `cnt_done` with `cur_val` == `num` → `hit` = 1, not `miss`.
- Full game: 4 rounds with targets 5/3/7/6, scoring hit, miss, hit, hit:
  - `game_over` = 1 with `score` = 3 and `round` = 4.
  - `stop_key`/`cnt_done` are ignored in OVER.
  - `start_key` → IDLE with all counters cleared; the next game's first target is 4.
- Reset mid-RUN: assert `rst` while `cst` = 1 → `cst` = 0 within the same cycle. State returns to IDLE and the LFSR returns to 101.
